// File: rtl/ascon_pkg.sv
// Shared Ascon types: the five-word permutation state and the 4-bit round index.
package ascon_pkg;

    // Packed with an ascending word range so element 0 is S0 and element 4 is S4.
    typedef logic [0:4][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

endpackage

// File: rtl/constant_addition_layer.sv
// Ascon p_C layer: XORs the round constant into S2 and registers the full state.
// The p8 schedule reuses the p12 table shifted by four entries.
module constant_addition_layer
    import ascon_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic         round_config_i,
    input  rnd_t         rnd_i,
    input  ascon_state_t state_array_i,
    output ascon_state_t state_array_o,
    output logic         valid_o
);

    localparam logic [0:15][63:0] AsconRcLut = '{
        64'hf0, 64'he1, 64'hd2, 64'hc3, 64'hb4, 64'ha5, 64'h96, 64'h87,
        64'h78, 64'h69, 64'h5a, 64'h4b, 64'h3c, 64'h2d, 64'h1e, 64'h0f
    };

    rnd_t         rc_idx;
    ascon_state_t state_next;

    // 4-bit add wraps out-of-range rounds back through the table.
    always_comb begin
        rc_idx        = rnd_i + (round_config_i ? 4'd0 : 4'd4);
        state_next    = state_array_i;
        state_next[2] = state_array_i[2] ^ AsconRcLut[rc_idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_array_o <= '0;
            valid_o       <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) state_array_o <= state_next;
        end
    end

endmodule

// File: tb/tb_constant_addition_layer.sv
// Scoreboard bench for constant_addition_layer: expected states are queued on
// drive and popped when the registered output appears one cycle later.
module tb_constant_addition_layer;
    import ascon_pkg::*;

    logic         clk_i          = 1'b0;
    logic         rst_ni         = 1'b0;
    logic         valid_i        = 1'b0;
    logic         round_config_i = 1'b0;
    rnd_t         rnd_i          = '0;
    ascon_state_t state_array_i  = '0;
    ascon_state_t state_array_o;
    logic         valid_o;

    int           vectors = 0;
    int           errors  = 0;
    ascon_state_t sb[$];
    ascon_state_t exp_s;
    logic [7:0]   rc_tab [16] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
                                  8'h78, 8'h69, 8'h5a, 8'h4b, 8'h3c, 8'h2d, 8'h1e, 8'h0f};

    constant_addition_layer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .round_config_i (round_config_i),
        .rnd_i          (rnd_i),
        .state_array_i  (state_array_i),
        .state_array_o  (state_array_o),
        .valid_o        (valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic ascon_state_t model(input logic cfg, input rnd_t rnd, input ascon_state_t st);
        rnd_t         i;
        ascon_state_t r;
        i    = rnd + (cfg ? 4'd0 : 4'd4);
        r    = st;
        r[2] = st[2] ^ {56'd0, rc_tab[i]};
        return r;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t r;
        for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
        return r;
    endfunction

    // Drives one cycle of inputs right after an edge; outputs are then sampled 1ns after the next edge.
    task automatic apply(input logic v, input logic cfg, input rnd_t r, input ascon_state_t st);
        valid_i        = v;
        round_config_i = cfg;
        rnd_i          = r;
        state_array_i  = st;
        if (v) sb.push_back(model(cfg, r, st));
        @(posedge clk_i);
        #1;
    endtask

    function automatic ascon_state_t pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        vectors++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got valid=%b state=%h, want valid=0 state=0", valid_o, state_array_o);
        end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        apply(1'b1, 1'b1, 4'd3, rand_state());
        exp_s = pop_exp();
        vectors++;
        if (valid_o !== 1'b1 || state_array_o !== exp_s) begin
            errors++;
            $display("FAIL reset_preload: got valid=%b state=%h, want valid=1 state=%h", valid_o, state_array_o, exp_s);
        end
        // Assert reset mid-cycle and check outputs clear before any clock edge.
        #2 rst_ni = 1'b0;
        valid_i = 1'b0;
        #1;
        vectors++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b state=%h, want valid=0 state=0", valid_o, state_array_o);
        end
        @(posedge clk_i); #1;
        vectors++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got valid=%b state=%h, want valid=0 state=0", valid_o, state_array_o);
        end
        sb.delete();
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_zero_sched(input logic cfg);
        for (int r = 0; r < 12; r++) begin
            apply(1'b1, cfg, rnd_t'(r), '0);
            exp_s = pop_exp();
            vectors++;
            if (valid_o !== 1'b1 || state_array_o !== exp_s) begin
                errors++;
                $display("FAIL zero_sched cfg=%0d rnd=%0d: got valid=%b state=%h, want state=%h",
                         cfg, r, valid_o, state_array_o, exp_s);
            end
        end
    endtask

    task automatic test_wrap();
        logic       cfg_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        rnd_t       rnd_t_[4] = '{4'd12, 4'd12, 4'd15, 4'd7};
        logic [7:0] want  [4] = '{8'h3c, 8'hf0, 8'hc3, 8'h4b};
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, cfg_t[k], rnd_t_[k], '0);
            void'(pop_exp());
            vectors++;
            if (valid_o !== 1'b1 || state_array_o[2] !== {56'd0, want[k]}) begin
                errors++;
                $display("FAIL wrap cfg=%0d rnd=%0d: got valid=%b S2=%h, want S2=%h",
                         cfg_t[k], rnd_t_[k], valid_o, state_array_o[2], want[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
                for (int r = 0; r <= 12; r++) begin
                    apply(1'b1, c[0], rnd_t'(r), rand_state());
                    exp_s = pop_exp();
                    vectors++;
                    if (valid_o !== 1'b1 || state_array_o !== exp_s) begin
                        errors++;
                        $display("FAIL random cfg=%0d rnd=%0d: got %h, want %h", c, r, state_array_o, exp_s);
                    end
                end
    endtask

    task automatic test_hold();
        ascon_state_t held;
        apply(1'b1, 1'b0, 4'd2, rand_state());
        held = pop_exp();
        vectors++;
        if (valid_o !== 1'b1 || state_array_o !== held) begin
            errors++;
            $display("FAIL hold_load: got valid=%b state=%h, want %h", valid_o, state_array_o, held);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, k[0], rnd_t'(k + 5), rand_state());
            vectors++;
            if (valid_o !== 1'b0 || state_array_o !== held) begin
                errors++;
                $display("FAIL hold_idle%0d: got valid=%b state=%h, want valid=0 state=%h",
                         k, valid_o, state_array_o, held);
            end
        end
        apply(1'b1, 1'b1, 4'd9, rand_state());
        exp_s = pop_exp();
        vectors++;
        if (valid_o !== 1'b1 || state_array_o !== exp_s) begin
            errors++;
            $display("FAIL hold_resume: got valid=%b state=%h, want %h", valid_o, state_array_o, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        ascon_state_t st;
        logic [63:0]  want [3] = '{64'hFFFF_FFFF_FFFF_FF0F, 64'hFFFF_FFFF_FFFF_FF1E, 64'hFFFF_FFFF_FFFF_FF2D};
        for (int r = 0; r < 3; r++) begin
            st    = rand_state();
            st[2] = '1;
            apply(1'b1, 1'b1, rnd_t'(r), st);
            exp_s = pop_exp();
            vectors++;
            if (valid_o !== 1'b1 || state_array_o !== exp_s || state_array_o[2] !== want[r]) begin
                errors++;
                $display("FAIL back_to_back rnd=%0d: got valid=%b state=%h, want S2=%h state=%h",
                         r, valid_o, state_array_o, want[r], exp_s);
            end
        end
        apply(1'b0, 1'b1, 4'd0, '0);
        vectors++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_drain: got valid=%b, want 0", valid_o);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_zero_sched(1'b1);
        test_zero_sched(1'b0);
        test_wrap();
        test_random();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/constant_addition_layer.md
# constant_addition_layer

Registered constant-addition layer (p_C) of the Ascon permutation per NIST SP 800-232. It XORs the round constant for the current round into state word S2 and passes S0, S1, S3 and S4 through unchanged. It supports both the 12-round (p12) and 8-round (p8) schedules. It sits at the head of the permutation round datapath, ahead of the substitution and linear-diffusion layers.

## Interface
- No parameters.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  input state and round are valid this cycle; load enable.
- round_config_i  input  1  1 = p12 schedule, 0 = p8 schedule.
- rnd_i  input  rnd_t (4)  round counter within the permutation, 0-based.
- state_array_i  input  ascon_state_t (5×64)  input state; element 0 = S0 … element 4 = S4.
- state_array_o  output  ascon_state_t (5×64)  registered output state.
- valid_o  output  1  state_array_o holds a result loaded from a valid input.

## Operation
- Constant table AsconRcLut: 16 × 64-bit entries, each a byte constant zero-extended into bits [7:0], upper 56 bits zero.
  - Indices 0..11: 0xf0, 0xe1, 0xd2, 0xc3, 0xb4, 0xa5, 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b.
  - Indices 12..15: 0x3c, 0x2d, 0x1e, 0x0f.
- Index computation, 4-bit modulo-16 arithmetic:
  - idx = rnd_i when round_config_i = 1.
  - idx = rnd_i + 4 (mod 16) when round_config_i = 0.
- Next state:
  - S2' = S2 ^ AsconRcLut[idx].
  - S0', S1', S3', S4' = input words unchanged, bit-exact.
- p12 uses rnd 0..11, giving constants 0xf0..0x4b. p8 uses rnd 0..7, giving constants 0xb4..0x4b.
- Out-of-range rounds are not flagged. They wrap through the table:
  - cfg = 1, rnd = 12 → 0x3c.
  - cfg = 0, rnd = 12 → idx 0 → 0xf0.
  - cfg = 0, rnd = 15 → idx 3 → 0xc3.
- round_config_i is sampled every valid cycle; no sticky mode.

## Timing
- Reset (rst_ni low, asynchronous): state_array_o = all zeros and valid_o = 0, immediately and for as long as reset is held.
- Latency is 1 cycle. Inputs sampled at edge N with valid_i = 1 appear on state_array_o at edge N, and valid_o = 1 after edge N.
- valid_i = 0 at an edge:
  - state_array_o holds its previous value.
  - valid_o = 0.
- Back-to-back valid inputs give full throughput, one state per cycle. No backpressure and no ready signal.
- Reset asserted mid-stream discards the in-flight result. The first valid input after release behaves as in the first-cycle case.
- No combinational path from inputs to outputs.

## Structure
- ascon_pkg (shared) holds:
  - ascon_state_t: array [0:4] of logic [63:0].
  - rnd_t: logic [3:0].
- AsconRcLut is a localparam declared inside constant_addition_layer and reachable hierarchically as dut.AsconRcLut, so benches can compute expected values from it.
- Single module, no sub-modules. The constant lookup and XOR form a combinational block feeding one output register plus the valid flop.

## Test plan
- Reset: assert rst_ni = 0 mid-cycle with nonzero outputs → state_array_o = 0 and valid_o = 0 without waiting for a clock edge.
- p12 zero state: cfg = 1, state all zeros, rnd 0..11 with valid_i = 1 → next cycle S2 = 0xf0, 0xe1 … 0x4b; S0, S1, S3, S4 = 0; valid_o = 1.
- p8 zero state: cfg = 0, state all zeros, rnd 0..11 → S2 = AsconRcLut[rnd + 4]:
  - rnd 0 → 0xb4.
  - rnd 7 → 0x4b.
  - rnd 8 → 0x3c.
  - rnd 11 → 0x0f.
- Random: 20+ random states and rnd 0..12 for each cfg →
  - S2 = in.S2 ^ AsconRcLut[(rnd + (cfg ? 0 : 4)) mod 16].
  - Other words bit-exact.
  - Includes wrap cases cfg = 1/rnd = 12 → 0x3c and cfg = 0/rnd = 12 → 0xf0.
- Hold: after one valid load, drive valid_i = 0 with changing inputs for 3 cycles → state_array_o unchanged and valid_o = 0. Then valid_i = 1 → new result 1 cycle later.
- Throughput: consecutive valid inputs with rnd 0, 1, 2 (cfg = 1, S2 = 0xFFFF_FFFF_FFFF_FFFF) → outputs on successive cycles with S2 = …FF0F, …FF1E, …FF2D.
